vote_booth_arbiter: RTL

//  Shares the single ballot-tally datapath between N_BOOTH voting booths. Each booth must be

---
 rtl/vote_booth_arbiter_pkg.sv | 9 +
 rtl/vote_booth_arbiter_if.sv | 29 ++
 rtl/vote_booth_arbiter_rr_pick.sv | 32 +++
 rtl/vote_booth_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/vote_booth_arbiter_pkg.sv
// vote_pkg: shared FSM state encoding and default widths for the vote booth arbiter
// Ports: none (package)
package vote_pkg;
    typedef enum logic [1:0] {IDLE, COMMIT, CLOSED, CLEARING} state_t;
    localparam int N_BOOTH_DEF = 4;
    localparam int CAND_W_DEF  = 4;
    localparam int CNT_W_DEF   = 12;
    localparam int CAND_TOTAL  = 0;
endpackage

// File: rtl/vote_booth_arbiter_if.sv
// vote_booth_arbiter_if: booth/officer/tally bundle for the vote booth arbiter
// Ports: arm, booth_req, booth_cand, tally_busy flow into the arbiter (slave inputs);
//        booth_ack, booth_err, armed, tally_we, tally_cand, accepted flow out of it
interface vote_booth_arbiter_if
    import vote_pkg::*;
#(
    parameter int N_BOOTH = N_BOOTH_DEF,
    parameter int CAND_W  = CAND_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic [N_BOOTH-1:0]        arm;
    logic [N_BOOTH-1:0]        booth_req;
    logic [N_BOOTH*CAND_W-1:0] booth_cand;
    logic                      tally_busy;
    logic [N_BOOTH-1:0]        booth_ack;
    logic [N_BOOTH-1:0]        booth_err;
    logic [N_BOOTH-1:0]        armed;
    logic                      tally_we;
    logic [CAND_W-1:0]         tally_cand;
    logic [CNT_W-1:0]          accepted;
    modport slave (
        input  arm, booth_req, booth_cand, tally_busy,
        output booth_ack, booth_err, armed, tally_we, tally_cand, accepted
    );
    modport master (
        output arm, booth_req, booth_cand, tally_busy,
        input  booth_ack, booth_err, armed, tally_we, tally_cand, accepted
    );
endinterface

// File: rtl/vote_booth_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at/after ptr
// Ports: req (request vector), ptr (start index) -> gnt (one-hot), idx (winner index), vld (any request)
module rr_pick #(
    parameter int N_BOOTH = 4
) (
    input  logic [N_BOOTH-1:0]         req,
    input  logic [$clog2(N_BOOTH)-1:0] ptr,
    output logic [N_BOOTH-1:0]         gnt,
    output logic [$clog2(N_BOOTH)-1:0] idx,
    output logic                       vld
);
    localparam int IW = $clog2(N_BOOTH);
    int s;
    logic [IW-1:0] k;
    // Scan offsets from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        s = 0;
        k = '0;
        for (int i = N_BOOTH - 1; i >= 0; i--) begin
            s = int'(ptr) + i;
            s = s >= N_BOOTH ? s - N_BOOTH : s;
            k = IW'(s);
            if (req[k]) begin
                idx = k;
                vld = 1'b1;
            end
        end
        gnt = vld ? N_BOOTH'(1) << idx : '0;
    end
endmodule

// File: rtl/vote_booth_arbiter.sv
// vote_booth_arbiter: round-robin sharing of the tally datapath between armed voting booths
// Ports: clk, Power (async active-high reset), Close (polls closed), Clear (sync clear),
//        bus (slave): arm/booth_req/booth_cand/tally_busy in; booth_ack/booth_err/armed/
//        tally_we/tally_cand/accepted out, all registered
module vote_booth_arbiter
    import vote_pkg::*;
#(
    parameter int N_BOOTH = N_BOOTH_DEF,
    parameter int CAND_W  = CAND_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic clk,
    input logic Power,
    input logic Close,
    input logic Clear,
    vote_booth_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_BOOTH);
    state_t state, state_n;
    logic [N_BOOTH-1:0] armed_q, armed_n, ack_q, ack_n, err_q, err_n, ack_mask, gnt;
    logic [IW-1:0] rr_q, rr_n, w;
    logic vld, we_q, we_n;
    logic [CAND_W-1:0] tc_q, tc_n, w_cand;
    logic [CNT_W-1:0] acc_q, acc_n;
    // A booth answered this cycle still holds req until it sees the answer; keep it out of the race.
    assign ack_mask = ack_q | err_q;
    assign w_cand = bus.booth_cand[int'(w)*CAND_W +: CAND_W];
    rr_pick #(.N_BOOTH(N_BOOTH)) u_pick (
        .req(bus.booth_req & ~ack_mask),
        .ptr(rr_q),
        .gnt(gnt),
        .idx(w),
        .vld(vld)
    );
    always_comb begin
        state_n = state;
        // Arming is frozen while closed; a booth being acked cannot be re-armed by a coincident pulse.
        armed_n = armed_q | ((Clear || state == CLOSED) ? '0 : (bus.arm & ~ack_q));
        rr_n = rr_q;
        acc_n = acc_q;
        ack_n = '0;
        err_n = '0;
        we_n = 1'b0;
        tc_n = '0;
        if (Clear) begin
            state_n = CLEARING;
            armed_n = '0;
            acc_n = '0;
            rr_n = '0;
        end else begin
            case (state)
                IDLE:
                    if (Close)
                        state_n = CLOSED;
                    else if (!bus.tally_busy && vld) begin
                        if (armed_q[w] && w_cand != CAND_W'(CAND_TOTAL)) begin
                            state_n = COMMIT;
                            we_n = 1'b1;
                            tc_n = w_cand;
                            ack_n = gnt;
                            armed_n = armed_n & ~gnt;
                            acc_n = acc_q + CNT_W'(~&acc_q);
                            rr_n = (w == IW'(N_BOOTH - 1)) ? '0 : w + 1'b1;
                        end else
                            err_n = gnt;
                    end
                COMMIT, CLEARING:
                    state_n = Close ? CLOSED : IDLE;
                CLOSED: begin
                    state_n = Close ? CLOSED : IDLE;
                    err_n = Close ? gnt : '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge Power)
        if (Power) begin
            state <= IDLE;
            armed_q <= '0;
            rr_q <= '0;
            acc_q <= '0;
            ack_q <= '0;
            err_q <= '0;
            we_q <= 1'b0;
            tc_q <= '0;
        end else begin
            state <= state_n;
            armed_q <= armed_n;
            rr_q <= rr_n;
            acc_q <= acc_n;
            ack_q <= ack_n;
            err_q <= err_n;
            we_q <= we_n;
            tc_q <= tc_n;
        end
    assign bus.booth_ack = ack_q;
    assign bus.booth_err = err_q;
    assign bus.armed = armed_q;
    assign bus.tally_we = we_q;
    assign bus.tally_cand = tc_q;
    assign bus.accepted = acc_q;
endmodule
